// File: rtl/rv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared control definitions for the RV32I multicycle core. The datapath, the
// ALU decoder and the main controller all use these definitions:
//   - state_t     : main controller state encoding
//   - OP_*        : RV32I major opcodes understood by the controller
//   - IMM_*       : ImmSrc encodings
//   - ALUOP_*     : ALUOp encodings
//   - RES_*       : ResultSrc encodings
//   - SRCA_*      : ALUSrcA encodings
//   - SRCB_*      : ALUSrcB encodings
//   - decode_next : DECODE-state dispatch from opcode to the next state
// -----------------------------------------------------------------------------
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRPC   = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_BUBBLE = 7'b0000000;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // An all-zero opcode is a bubble: return to FETCH without retiring.
  // Anything not recognised lands in TRAP.
  function automatic state_t decode_next(input logic [6:0] op);
    state_t nxt;
    case (op)
      OP_LOAD, OP_STORE: nxt = S_MEMADR;
      OP_RTYPE:          nxt = S_EXECR;
      OP_ITYPE:          nxt = S_EXECI;
      OP_BRANCH:         nxt = S_BEQ;
      OP_JAL:            nxt = S_JAL;
      OP_JALR:           nxt = S_JALR;
      OP_LUI:            nxt = S_LUI;
      OP_AUIPC:          nxt = S_AUIPC;
      OP_BUBBLE:         nxt = S_FETCH;
      default:           nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/imm_src_decode.sv
// -----------------------------------------------------------------------------
// imm_src_decode
// Combinational opcode -> immediate-format select. Kept separate so the
// pipelined core can reuse it in its decode stage.
// Ports:
//   op      in  OP_W  opcode from instruction register
//   ImmSrc  out 3     I 000, S 001, B 010, J 011, U 100, anything else 000
// -----------------------------------------------------------------------------
module imm_src_decode
  import rv_ctrl_pkg::*;
#(
  parameter int OP_W = 7
) (
  input  logic [OP_W-1:0] op,
  output logic [2:0]      ImmSrc
);

  // Opcode to immediate format
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_LOAD, OP_ITYPE, OP_JALR: ImmSrc = IMM_I;
      OP_STORE:                   ImmSrc = IMM_S;
      OP_BRANCH:                  ImmSrc = IMM_B;
      OP_JAL:                     ImmSrc = IMM_J;
      OP_LUI, OP_AUIPC:           ImmSrc = IMM_U;
      default:                    ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_main_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_main_fsm
// Main controller of the RV32I multicycle core. It sequences
// FETCH/DECODE/EXECUTE/MEM/WB and drives the datapath mux selects and strobes.
// Parameters:
//   OP_W           opcode width (the opcode tables are 7 bits)
//   MEM_HANDSHAKE  1: FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0: ready assumed
//   CNT_W          width of the retired-instruction counter
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   op                opcode from the instruction register
//   mem_ready         unified memory access completes this cycle
//   RegWrite/MemWrite/IRWrite/PCUpdate/Branch   strobes
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp  datapath selects
//   ImmSrc            immediate format, decoded directly from op
//   illegal           sticky flag: an unknown opcode reached DECODE
//   instr_done        1-cycle pulse on the last state of each instruction
//   retired           count of instr_done pulses, wraps
// -----------------------------------------------------------------------------
module multicycle_main_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int OP_W          = 7,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ready,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCUpdate,
  output logic             Branch,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  state_t           state_r;
  state_t           next_state_s;
  logic             illegal_r;
  logic [CNT_W-1:0] retired_r;
  logic             mem_rdy_s;

  // Ungated strobes straight from the state decode
  logic reg_write_s;
  logic mem_write_s;
  logic ir_write_s;
  logic pc_update_s;
  logic branch_s;
  logic instr_done_s;

  // Without the handshake every memory access completes in one cycle
  assign mem_rdy_s = MEM_HANDSHAKE ? mem_ready : 1'b1;

  imm_src_decode #(
    .OP_W (OP_W)
  ) u_imm_src_decode (
    .op     (op),
    .ImmSrc (ImmSrc)
  );

  // State register, sticky illegal flag and retired counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_FETCH;
      illegal_r <= 1'b0;
      retired_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (next_state_s == S_TRAP) begin
        illegal_r <= 1'b1;
      end else begin
        illegal_r <= illegal_r;
      end
      if (instr_done_s) begin
        retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  // Next-state logic and Moore output decode (strobes still ungated)
  always_comb begin
    next_state_s = state_r;
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    instr_done_s = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    ResultSrc    = RES_ALUOUT;
    ALUOp        = ALUOP_ADD;
    case (state_r)
      S_FETCH: begin
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURESULT;
        ir_write_s   = mem_rdy_s;
        pc_update_s  = mem_rdy_s;
        next_state_s = mem_rdy_s ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target OldPC + imm is computed here for BEQ
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_IMM;
        next_state_s = decode_next(op);
      end
      S_MEMADR: begin
        ALUSrcA      = SRCA_RS1;
        ALUSrcB      = SRCB_IMM;
        next_state_s = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc       = 1'b1;
        next_state_s = mem_rdy_s ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc    = RES_READDATA;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc       = 1'b1;
        mem_write_s  = mem_rdy_s;
        instr_done_s = mem_rdy_s;
        next_state_s = mem_rdy_s ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA      = SRCA_RS1;
        ALUOp        = ALUOP_FUNCT;
        next_state_s = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA      = SRCA_RS1;
        ALUSrcB      = SRCB_IMM;
        ALUOp        = ALUOP_FUNCT;
        next_state_s = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA      = SRCA_RS1;
        ALUSrcB      = SRCB_IMM;
        ALUOp        = ALUOP_PASSB;
        next_state_s = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_IMM;
        next_state_s = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BEQ: begin
        // rs1 - rs2 drives Zero; PC load comes from the target latched in DECODE
        ALUSrcA      = SRCA_RS1;
        ALUOp        = ALUOP_SUB;
        branch_s     = 1'b1;
        instr_done_s = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JAL: begin
        // PC takes the jump target in ALUOut while the ALU forms OldPC+4 for rd
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        pc_update_s  = 1'b1;
        next_state_s = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA      = SRCA_RS1;
        ALUSrcB      = SRCB_IMM;
        next_state_s = S_JALRPC;
      end
      S_JALRPC: begin
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        pc_update_s  = 1'b1;
        next_state_s = S_ALUWB;
      end
      S_TRAP: begin
        next_state_s = S_TRAP;
      end
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  // Strobes are held low for as long as reset is asserted
  always_comb begin
    if (reset) begin
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCUpdate   = 1'b0;
      Branch     = 1'b0;
      instr_done = 1'b0;
    end else begin
      RegWrite   = reg_write_s;
      MemWrite   = mem_write_s;
      IRWrite    = ir_write_s;
      PCUpdate   = pc_update_s;
      Branch     = branch_s;
      instr_done = instr_done_s;
    end
  end

  assign illegal = illegal_r;
  assign retired = retired_r;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_main_fsm
// Directed bench for multicycle_main_fsm. The main instance uses the handshake
// and a 32-bit counter; a second instance with no handshake and a 2-bit
// counter covers the free-running memory case and counter wrap.
// Control outputs are packed as
//   {RegWrite, MemWrite, IRWrite, PCUpdate, Branch, AdrSrc,
//    ALUSrcA, ALUSrcB, ResultSrc, ALUOp, instr_done}
// -----------------------------------------------------------------------------
module tb_multicycle_main_fsm;

  logic        clk;
  logic        reset;
  logic [6:0]  op;
  logic        mem_ready;
  logic        RegWrite, MemWrite, IRWrite, PCUpdate, Branch, AdrSrc;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic [2:0]  ImmSrc;
  logic        illegal, instr_done;
  logic [31:0] retired;

  logic        reset2;
  logic [6:0]  op2;
  logic        mem_ready2;
  logic        RegWrite2, MemWrite2, IRWrite2, PCUpdate2, Branch2, AdrSrc2;
  logic [1:0]  ALUSrcA2, ALUSrcB2, ResultSrc2, ALUOp2;
  logic [2:0]  ImmSrc2;
  logic        illegal2, instr_done2;
  logic [1:0]  retired2;

  int checks;
  int failures;

  multicycle_main_fsm #(.OP_W(7), .MEM_HANDSHAKE(1'b1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCUpdate(PCUpdate), .Branch(Branch), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal(illegal),
    .instr_done(instr_done), .retired(retired)
  );

  multicycle_main_fsm #(.OP_W(7), .MEM_HANDSHAKE(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset2), .op(op2), .mem_ready(mem_ready2),
    .RegWrite(RegWrite2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
    .PCUpdate(PCUpdate2), .Branch(Branch2), .AdrSrc(AdrSrc2),
    .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ResultSrc(ResultSrc2),
    .ALUOp(ALUOp2), .ImmSrc(ImmSrc2), .illegal(illegal2),
    .instr_done(instr_done2), .retired(retired2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [14:0] ctl  = {RegWrite, MemWrite, IRWrite, PCUpdate, Branch, AdrSrc,
                      ALUSrcA, ALUSrcB, ResultSrc, ALUOp, instr_done};
  wire [14:0] ctl2 = {RegWrite2, MemWrite2, IRWrite2, PCUpdate2, Branch2, AdrSrc2,
                      ALUSrcA2, ALUSrcB2, ResultSrc2, ALUOp2, instr_done2};

  function automatic logic [14:0] cv(input logic rw, input logic mw, input logic ir,
                                     input logic pc, input logic br, input logic adr,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] res, input logic [1:0] aop,
                                     input logic done);
    return {rw, mw, ir, pc, br, adr, a, b, res, aop, done};
  endfunction

  // Hand-derived expected control words per state
  localparam logic [14:0] E_FETCH    = 15'b0_0_1_1_0_0_00_10_10_00_0;
  localparam logic [14:0] E_FETCH_RS = 15'b0_0_0_0_0_0_00_10_10_00_0;
  localparam logic [14:0] E_FETCH_W  = 15'b0_0_0_0_0_0_00_10_10_00_0;
  localparam logic [14:0] E_DECODE   = 15'b0_0_0_0_0_0_01_01_00_00_0;
  localparam logic [14:0] E_MEMADR   = 15'b0_0_0_0_0_0_10_01_00_00_0;
  localparam logic [14:0] E_MEMREAD  = 15'b0_0_0_0_0_1_00_00_00_00_0;
  localparam logic [14:0] E_MEMWB    = 15'b1_0_0_0_0_0_00_00_01_00_1;
  localparam logic [14:0] E_MEMWR_W  = 15'b0_0_0_0_0_1_00_00_00_00_0;
  localparam logic [14:0] E_MEMWR_GO = 15'b0_1_0_0_0_1_00_00_00_00_1;
  localparam logic [14:0] E_JALR     = 15'b0_0_0_0_0_0_10_01_00_00_0;
  localparam logic [14:0] E_JALRPC   = 15'b0_0_0_1_0_0_01_10_00_00_0;
  localparam logic [14:0] E_ALUWB    = 15'b1_0_0_0_0_0_00_00_00_00_1;
  localparam logic [14:0] E_BEQ      = 15'b0_0_0_0_1_0_10_00_00_01_1;
  localparam logic [14:0] E_EXECR    = 15'b0_0_0_0_0_0_10_00_00_10_0;
  localparam logic [14:0] E_ZERO     = 15'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    op         = 7'b0000000;
    mem_ready  = 1'b1;
    reset2     = 1'b1;
    op2        = 7'b0110011;
    mem_ready2 = 1'b0;

    // 1: reset held two clocks
    step();
    step();
    chk("reset_ctl", {17'd0, ctl}, {17'd0, E_FETCH_RS});
    chk("reset_retired", retired, 32'd0);
    chk("reset_illegal", {31'd0, illegal}, 32'd0);
    reset = 1'b0;
    #1;
    chk("fetch_ctl", {17'd0, ctl}, {17'd0, E_FETCH});
    chk("fetch_wait_check_cv", {17'd0, cv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10,
                                            2'b10, 2'b00, 1'b0)}, {17'd0, ctl});

    // FETCH stalls with no strobes while memory is not ready
    mem_ready = 1'b0;
    #1;
    chk("fetch_wait_ctl", {17'd0, ctl}, {17'd0, E_FETCH_W});
    step();
    chk("fetch_wait_hold", {17'd0, ctl}, {17'd0, E_FETCH_W});
    mem_ready = 1'b1;
    #1;

    // 2: lw, five clocks
    op = 7'b0000011;
    #1;
    chk("lw_immsrc", {29'd0, ImmSrc}, 32'd0);
    step(); chk("lw_decode", {17'd0, ctl}, {17'd0, E_DECODE});
    step(); chk("lw_memadr", {17'd0, ctl}, {17'd0, E_MEMADR});
    step(); chk("lw_memread", {17'd0, ctl}, {17'd0, E_MEMREAD});
    step(); chk("lw_memwb", {17'd0, ctl}, {17'd0, E_MEMWB});
    chk("lw_retired_before", retired, 32'd0);
    step(); chk("lw_back_fetch", {17'd0, ctl}, {17'd0, E_FETCH});
    chk("lw_retired", retired, 32'd1);

    // 3: sw with three not-ready cycles in MEMWRITE
    op = 7'b0100011;
    #1;
    chk("sw_immsrc", {29'd0, ImmSrc}, 32'd1);
    step(); chk("sw_decode", {17'd0, ctl}, {17'd0, E_DECODE});
    step(); chk("sw_memadr", {17'd0, ctl}, {17'd0, E_MEMADR});
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sw_wait", {17'd0, ctl}, {17'd0, E_MEMWR_W});
    end
    mem_ready = 1'b1;
    #1;
    chk("sw_write", {17'd0, ctl}, {17'd0, E_MEMWR_GO});
    step(); chk("sw_back_fetch", {17'd0, ctl}, {17'd0, E_FETCH});
    chk("sw_retired", retired, 32'd2);

    // 4: jalr then beq
    op = 7'b1100111;
    step(); chk("jalr_decode", {17'd0, ctl}, {17'd0, E_DECODE});
    step(); chk("jalr_exec", {17'd0, ctl}, {17'd0, E_JALR});
    step(); chk("jalr_pc", {17'd0, ctl}, {17'd0, E_JALRPC});
    step(); chk("jalr_wb", {17'd0, ctl}, {17'd0, E_ALUWB});
    step(); chk("jalr_retired", retired, 32'd3);
    op = 7'b1100011;
    #1;
    chk("beq_immsrc", {29'd0, ImmSrc}, 32'd2);
    step(); chk("beq_decode", {17'd0, ctl}, {17'd0, E_DECODE});
    step(); chk("beq_exec", {17'd0, ctl}, {17'd0, E_BEQ});
    step(); chk("beq_back_fetch", {17'd0, ctl}, {17'd0, E_FETCH});
    chk("beq_retired", retired, 32'd4);

    // 5: illegal opcode traps until reset
    op = 7'b1111111;
    step(); chk("trap_decode_illegal", {31'd0, illegal}, 32'd0);
    step();
    for (int i = 0; i < 10; i++) begin
      chk("trap_ctl", {17'd0, ctl}, {17'd0, E_ZERO});
      chk("trap_illegal", {31'd0, illegal}, 32'd1);
      step();
    end
    chk("trap_retired", retired, 32'd4);
    reset = 1'b1;
    step();
    chk("trap_reset_illegal", {31'd0, illegal}, 32'd0);
    chk("trap_reset_retired", retired, 32'd0);
    reset = 1'b0;
    #1;
    chk("trap_reset_fetch", {17'd0, ctl}, {17'd0, E_FETCH});

    // Bubble opcode: DECODE goes straight back to FETCH without retiring
    op = 7'b0000000;
    step(); chk("bubble_decode", {17'd0, ctl}, {17'd0, E_DECODE});
    step(); chk("bubble_fetch", {17'd0, ctl}, {17'd0, E_FETCH});
    chk("bubble_retired", retired, 32'd0);

    // Reset mid-instruction abandons it without retiring
    op = 7'b0110011;
    step(); step();
    reset = 1'b1;
    #1;
    chk("midrst_strobes", {17'd0, ctl}, {17'd0, E_EXECR & 15'b000001111111110});
    step();
    reset = 1'b0;
    #1;
    chk("midrst_fetch", {17'd0, ctl}, {17'd0, E_FETCH});
    chk("midrst_retired", retired, 32'd0);

    // 6: no handshake, mem_ready low, R-type in four clocks, 2-bit counter wraps
    reset2 = 1'b0;
    #1;
    for (int n = 1; n <= 4; n++) begin
      chk("nohs_fetch", {17'd0, ctl2}, {17'd0, E_FETCH});
      step(); chk("nohs_decode", {17'd0, ctl2}, {17'd0, E_DECODE});
      step(); chk("nohs_execr", {17'd0, ctl2}, {17'd0, E_EXECR});
      step(); chk("nohs_aluwb", {17'd0, ctl2}, {17'd0, E_ALUWB});
      step();
      chk("nohs_retired", {30'd0, retired2}, 32'(n % 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
